// File: rtl/cpu6_pipereg_stage_pkg.sv
// Shared types and constants for the cpu6 pipeline stage register.
package cpu6_pipereg_stage_pkg;

    localparam int unsigned CPU6_PSTG_STATE_SIZE = 2;

    // Encoding doubles as the held-entry count, so occupancy is the raw state.
    typedef enum logic [CPU6_PSTG_STATE_SIZE-1:0] {
        StEmpty   = 2'd0,
        StFull    = 2'd1,
        StSkidded = 2'd2
    } pstg_state_e;

endpackage

// File: rtl/cpu6_pipereg_stage_if.sv
// Handshake bundle between an upstream producer, the stage and its consumer.
interface cpu6_pipereg_stage_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    // Environment side: drives the stage inputs, observes its outputs.
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // Stage side.
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/cpu6_dffrle.sv
// Enable flop with asynchronous active-low reset to zero.
module cpu6_dffrle #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable only; otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu6_pipereg_stage.sv
// Pipeline stage register with valid/ready handshake, optional skid entry
// and flush-to-bubble.
module cpu6_pipereg_stage
    import cpu6_pipereg_stage_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter bit          SKID          = 1'b1,
    parameter bit          ZERO_ON_FLUSH = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    cpu6_pipereg_stage_if.slave bus
);

    logic [CPU6_PSTG_STATE_SIZE-1:0] state_raw_q;
    pstg_state_e                     state_q;
    pstg_state_e                     state_d;

    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] m_d;
    logic              m_en;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] s_d;
    logic              s_en;

    logic out_valid;
    logic in_ready;
    logic accept;
    logic deliver;

    assign state_q = pstg_state_e'(state_raw_q);

    // Stage state register; updates every cycle.
    cpu6_dffrle #(
        .W (CPU6_PSTG_STATE_SIZE)
    ) u_state (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (state_d),
        .q     (state_raw_q)
    );

    // Main entry; always the one presented downstream.
    cpu6_dffrle #(
        .W (DATA_W)
    ) u_m (
        .clk   (clk),
        .reset (reset),
        .en    (m_en),
        .d     (m_d),
        .q     (m_q)
    );

    if (SKID) begin : gen_skid
        // Catches the entry accepted in the cycle after downstream stalls.
        cpu6_dffrle #(
            .W (DATA_W)
        ) u_s (
            .clk   (clk),
            .reset (reset),
            .en    (s_en),
            .d     (s_d),
            .q     (s_q)
        );
    end else begin : gen_no_skid
        assign s_q = '0;
    end

    assign out_valid = (state_q != StEmpty);

    // With a skid entry, ready comes straight from state; otherwise it is
    // the classic combinational ready.
    if (SKID) begin : gen_ready_reg
        assign in_ready = (state_q != StSkidded);
    end else begin : gen_ready_comb
        assign in_ready = ~out_valid | bus.out_ready;
    end

    assign accept  = bus.in_valid & in_ready;
    assign deliver = out_valid & bus.out_ready;

    // Next-state and load-select; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        m_en    = 1'b0;
        m_d     = bus.in_data;
        s_en    = 1'b0;
        s_d     = bus.in_data;
        if (bus.flush) begin
            state_d = StEmpty;
            if (ZERO_ON_FLUSH) begin
                m_en = 1'b1;
                m_d  = '0;
                s_en = SKID;
                s_d  = '0;
            end
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StFull;
                        m_en    = 1'b1;
                    end
                end
                StFull: begin
                    if (deliver && accept) begin
                        m_en = 1'b1;
                    end else if (deliver) begin
                        state_d = StEmpty;
                    end else if (accept && SKID) begin
                        state_d = StSkidded;
                        s_en    = 1'b1;
                    end
                end
                StSkidded: begin
                    if (deliver) begin
                        state_d = StFull;
                        m_en    = 1'b1;
                        m_d     = s_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
    assign bus.out_data  = m_q;
    assign bus.occupancy = state_raw_q;

endmodule

// File: tb/tb_cpu6_pipereg_stage.sv
// Directed bench for cpu6_pipereg_stage across three configurations.
module tb_cpu6_pipereg_stage;

    logic clk;
    logic reset;

    int n_cmp;
    int n_err;

    cpu6_pipereg_stage_if #(.DATA_W(32)) b_a ();  // SKID=1, ZERO_ON_FLUSH=1
    cpu6_pipereg_stage_if #(.DATA_W(32)) b_b ();  // SKID=1, ZERO_ON_FLUSH=0
    cpu6_pipereg_stage_if #(.DATA_W(32)) b_c ();  // SKID=0, ZERO_ON_FLUSH=1

    cpu6_pipereg_stage #(
        .DATA_W        (32),
        .SKID          (1'b1),
        .ZERO_ON_FLUSH (1'b1)
    ) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (b_a)
    );

    cpu6_pipereg_stage #(
        .DATA_W        (32),
        .SKID          (1'b1),
        .ZERO_ON_FLUSH (1'b0)
    ) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_b)
    );

    cpu6_pipereg_stage #(
        .DATA_W        (32),
        .SKID          (1'b0),
        .ZERO_ON_FLUSH (1'b1)
    ) u_c (
        .clk   (clk),
        .reset (reset),
        .bus   (b_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        b_a.flush = 0; b_a.in_valid = 1; b_a.in_data = 32'hDEADBEEF; b_a.out_ready = 0;
        b_b.flush = 0; b_b.in_valid = 0; b_b.in_data = 0; b_b.out_ready = 0;
        b_c.flush = 0; b_c.in_valid = 0; b_c.in_data = 0; b_c.out_ready = 0;

        // Reset held with a valid offer pending.
        step(); step();
        check_eq("rst_out_valid", {31'd0, b_a.out_valid}, 32'd0);
        check_eq("rst_out_data", b_a.out_data, 32'd0);
        check_eq("rst_in_ready", {31'd0, b_a.in_ready}, 32'd1);
        check_eq("rst_occupancy", {30'd0, b_a.occupancy}, 32'd0);
        check_eq("rst_c_in_ready", {31'd0, b_c.in_ready}, 32'd1);
        #3 reset = 1'b1;
        step();
        check_eq("rel_out_valid", {31'd0, b_a.out_valid}, 32'd1);
        check_eq("rel_out_data", b_a.out_data, 32'hDEADBEEF);
        check_eq("rel_occupancy", {30'd0, b_a.occupancy}, 32'd1);
        b_a.in_valid = 0; b_a.out_ready = 1;
        step();
        check_eq("rel_drain", {31'd0, b_a.out_valid}, 32'd0);

        // Back-to-back stream.
        b_a.in_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            b_a.in_data = i;
            step();
            check_eq("stream_data", b_a.out_data, i);
            check_eq("stream_occ", {30'd0, b_a.occupancy}, 32'd1);
        end
        b_a.in_valid = 0;
        step();
        check_eq("stream_end", {31'd0, b_a.out_valid}, 32'd0);

        // Skid: stall downstream for three cycles while offering 0x11, 0x12.
        b_a.in_valid = 1; b_a.in_data = 32'h10;
        step();
        b_a.out_ready = 0; b_a.in_data = 32'h11;
        step();
        check_eq("skid_occ", {30'd0, b_a.occupancy}, 32'd2);
        check_eq("skid_in_ready", {31'd0, b_a.in_ready}, 32'd0);
        check_eq("skid_head", b_a.out_data, 32'h10);
        b_a.in_data = 32'h12;
        step(); step();
        check_eq("skid_hold_occ", {30'd0, b_a.occupancy}, 32'd2);
        check_eq("skid_hold_head", b_a.out_data, 32'h10);
        b_a.out_ready = 1;
        step();
        check_eq("skid_out1", b_a.out_data, 32'h11);
        check_eq("skid_out1_occ", {30'd0, b_a.occupancy}, 32'd1);
        check_eq("skid_out1_rdy", {31'd0, b_a.in_ready}, 32'd1);
        step();
        check_eq("skid_out2", b_a.out_data, 32'h12);
        b_a.in_valid = 0;
        step();
        check_eq("skid_drain", {31'd0, b_a.out_valid}, 32'd0);

        // Flush while SKIDDED, zeroing and retaining variants in parallel.
        b_a.out_ready = 0; b_a.in_valid = 1; b_a.in_data = 32'h10;
        b_b.out_ready = 0; b_b.in_valid = 1; b_b.in_data = 32'h10;
        step();
        b_a.in_data = 32'h11; b_b.in_data = 32'h11;
        step();
        check_eq("pre_flush_occ_a", {30'd0, b_a.occupancy}, 32'd2);
        check_eq("pre_flush_occ_b", {30'd0, b_b.occupancy}, 32'd2);
        b_a.in_valid = 0; b_b.in_valid = 0;
        b_a.flush = 1; b_b.flush = 1;
        step();
        b_a.flush = 0; b_b.flush = 0;
        check_eq("flush_z_valid", {31'd0, b_a.out_valid}, 32'd0);
        check_eq("flush_z_occ", {30'd0, b_a.occupancy}, 32'd0);
        check_eq("flush_z_data", b_a.out_data, 32'd0);
        check_eq("flush_z_rdy", {31'd0, b_a.in_ready}, 32'd1);
        check_eq("flush_h_valid", {31'd0, b_b.out_valid}, 32'd0);
        check_eq("flush_h_occ", {30'd0, b_b.occupancy}, 32'd0);
        check_eq("flush_h_data", b_b.out_data, 32'h10);

        // Flush coincident with accept of 0x55: entry dropped.
        b_a.out_ready = 1; b_a.in_valid = 1; b_a.in_data = 32'h55; b_a.flush = 1;
        b_b.out_ready = 1; b_b.in_valid = 1; b_b.in_data = 32'h55; b_b.flush = 1;
        step();
        b_a.flush = 0; b_a.in_valid = 0;
        b_b.flush = 0; b_b.in_valid = 0;
        check_eq("flacc_z_valid", {31'd0, b_a.out_valid}, 32'd0);
        check_eq("flacc_z_data", b_a.out_data, 32'd0);
        check_eq("flacc_h_valid", {31'd0, b_b.out_valid}, 32'd0);
        check_eq("flacc_h_data", b_b.out_data, 32'h10);
        step();
        check_eq("flacc_z_later", {31'd0, b_a.out_valid}, 32'd0);
        check_eq("flacc_z_occ", {30'd0, b_a.occupancy}, 32'd0);

        // SKID=0: combinational ready and replace-in-place.
        b_c.in_valid = 1; b_c.in_data = 32'hA1;
        step();
        b_c.in_valid = 0;
        #1;
        check_eq("c_full_rdy_lo", {31'd0, b_c.in_ready}, 32'd0);
        b_c.out_ready = 1;
        #1;
        check_eq("c_full_rdy_hi", {31'd0, b_c.in_ready}, 32'd1);
        b_c.in_valid = 1; b_c.in_data = 32'hA2;
        step();
        check_eq("c_replace_data", b_c.out_data, 32'hA2);
        check_eq("c_replace_occ", {30'd0, b_c.occupancy}, 32'd1);
        b_c.out_ready = 0; b_c.in_data = 32'hA3;
        step();
        check_eq("c_stall_data", b_c.out_data, 32'hA2);
        check_eq("c_stall_occ", {30'd0, b_c.occupancy}, 32'd1);
        b_c.in_valid = 0; b_c.out_ready = 1;
        step();
        check_eq("c_drain", {31'd0, b_c.out_valid}, 32'd0);

        // Asynchronous reset mid-cycle clears held entry without a clock edge.
        b_a.out_ready = 0; b_a.in_valid = 1; b_a.in_data = 32'h77;
        step();
        b_a.in_valid = 0;
        check_eq("pre_arst_valid", {31'd0, b_a.out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, b_a.out_valid}, 32'd0);
        check_eq("arst_data", b_a.out_data, 32'd0);
        check_eq("arst_occ", {30'd0, b_a.occupancy}, 32'd0);
        #1 reset = 1'b1;
        step();
        check_eq("post_arst_valid", {31'd0, b_a.out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
